// File: rtl/hir_arith_pkg.sv
// hir_arith_pkg: shared types, limits and helpers for the HIR arithmetic helpers.
`default_nettype none

package hir_arith_pkg;

   localparam int MAC_MIN_LATENCY = 2;
   localparam int MAC_MAX_W       = 256;

   typedef struct packed {
      logic valid;
      logic acc_en;
      logic acc_clr;
   } mac_ctl_t;

   // Sign- or zero-extends the low in_w bits of value to the full carrier width;
   // callers narrow the result with a size cast, which is where truncation happens.
   function automatic logic [MAC_MAX_W-1:0] resize_ext(input logic [MAC_MAX_W-1:0] value,
                                                       input int in_w,
                                                       input logic is_signed);
      logic [MAC_MAX_W-1:0] r;
      for (int i = 0; i < MAC_MAX_W; i++)
         r[i] = (i < in_w) ? value[i] : (is_signed & value[8'(in_w - 1)]);
      return r;
   endfunction

   function automatic bit mac_params_ok(input int width, input int out_width, input int latency);
      return (width >= 2) && (out_width >= width) && (out_width <= 2 * width + 16) &&
             (out_width <= MAC_MAX_W) && (2 * width <= MAC_MAX_W) &&
             (latency >= MAC_MIN_LATENCY);
   endfunction

endpackage

`default_nettype wire

// File: rtl/mac_pipe_if.sv
// mac_pipe_if: operand/result bundle of the pipelined multiply-accumulate unit.
`default_nettype none

interface mac_pipe_if #(
   parameter int WIDTH     = 32,
   parameter int OUT_WIDTH = 64
);
   logic                 t;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 acc_en;
   logic                 acc_clr;
   logic [OUT_WIDTH-1:0] out;
   logic                 out_valid;
   logic                 ovf;

   modport master (output t, a, b, acc_en, acc_clr, input out, out_valid, ovf);
   modport slave  (input t, a, b, acc_en, acc_clr, output out, out_valid, ovf);
endinterface

`default_nettype wire

// File: rtl/delay_line.sv
// delay_line: WIDTH x DEPTH shift register with synchronous reset; DEPTH=0 is a wire.
`default_nettype none

module delay_line #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   generate
      if (DEPTH == 0) begin : g_pass
         logic unused_clk_rst;
         assign unused_clk_rst = clk ^ rst;
         assign dout = din;
      end else begin : g_regs
         logic [WIDTH-1:0] stage [DEPTH];

         always_ff @(posedge clk) begin
            if (rst) begin
               for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
            end else begin
               stage[0] <= din;
               for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
         end

         assign dout = stage[DEPTH-1];
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/mac_pipe.sv
// mac_pipe: fully pipelined multiply / multiply-accumulate, II=1, result LATENCY cycles after t.
`default_nettype none

module mac_pipe
   import hir_arith_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int OUT_WIDTH = 64,
   parameter int LATENCY   = 3,
   parameter bit SIGNED    = 1'b1
) (
   input  logic     clk,
   input  logic     rst,
   mac_pipe_if.slave bus
);

   generate
      if (!mac_params_ok(WIDTH, OUT_WIDTH, LATENCY)) begin : g_param_check
         $error("mac_pipe: illegal WIDTH/OUT_WIDTH/LATENCY combination");
      end
   endgenerate

   logic [WIDTH-1:0]     a_s1, b_s1;
   mac_ctl_t             ctl_s1, ctl_d;
   logic [2*WIDTH-1:0]   a_ext, b_ext, prod_full;
   logic [OUT_WIDTH-1:0] prod, prod_d, sum, acc, out_r;
   logic                 carry, sum_ovf, ovf_r, valid_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         a_s1   <= '0;
         b_s1   <= '0;
         ctl_s1 <= '0;
      end else begin
         a_s1           <= bus.a;
         b_s1           <= bus.b;
         ctl_s1.valid   <= bus.t;
         ctl_s1.acc_en  <= bus.acc_en;
         ctl_s1.acc_clr <= bus.acc_clr;
      end
   end

   always_comb begin
      a_ext     = SIGNED ? {{WIDTH{a_s1[WIDTH-1]}}, a_s1} : {{WIDTH{1'b0}}, a_s1};
      b_ext     = SIGNED ? {{WIDTH{b_s1[WIDTH-1]}}, b_s1} : {{WIDTH{1'b0}}, b_s1};
      prod_full = a_ext * b_ext;
      prod      = OUT_WIDTH'(resize_ext(MAC_MAX_W'(prod_full), 2 * WIDTH, SIGNED));
   end

   // First register of the delay is the stage-2 product; LATENCY=2 leaves it combinational.
   delay_line #(.WIDTH(OUT_WIDTH), .DEPTH(LATENCY - 2)) u_prod_dly (
      .clk  (clk),
      .rst  (rst),
      .din  (prod),
      .dout (prod_d)
   );

   delay_line #(.WIDTH($bits(mac_ctl_t)), .DEPTH(LATENCY - 2)) u_ctl_dly (
      .clk  (clk),
      .rst  (rst),
      .din  (ctl_s1),
      .dout (ctl_d)
   );

   always_comb begin
      {carry, sum} = {1'b0, acc} + {1'b0, prod_d};
      sum_ovf      = SIGNED ? ((acc[OUT_WIDTH-1] == prod_d[OUT_WIDTH-1]) &&
                               (sum[OUT_WIDTH-1] != acc[OUT_WIDTH-1]))
                            : carry;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc     <= '0;
         out_r   <= '0;
         ovf_r   <= 1'b0;
         valid_r <= 1'b0;
      end else begin
         valid_r <= ctl_d.valid;
         if (ctl_d.valid) begin
            if (!ctl_d.acc_en) begin
               out_r <= prod_d;
            end else if (ctl_d.acc_clr) begin
               acc   <= prod_d;
               out_r <= prod_d;
               ovf_r <= 1'b0;
            end else begin
               acc   <= sum;
               out_r <= sum;
               ovf_r <= ovf_r | sum_ovf;
            end
         end
      end
   end

   assign bus.out       = out_r;
   assign bus.out_valid = valid_r;
   assign bus.ovf       = ovf_r;

endmodule

`default_nettype wire

// File: tb/tb_mac_pipe.sv
// tb_mac_pipe: three mac_pipe configurations checked cycle by cycle against an exact-arithmetic model.
`default_nettype none

module tb_mac_pipe;

   typedef logic signed [135:0] big_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   mac_pipe_if #(.WIDTH(32), .OUT_WIDTH(64)) if0 ();
   mac_pipe_if #(.WIDTH(8),  .OUT_WIDTH(16)) if1 ();
   mac_pipe_if #(.WIDTH(16), .OUT_WIDTH(16)) if2 ();

   mac_pipe #(.WIDTH(32), .OUT_WIDTH(64), .LATENCY(3), .SIGNED(1'b1)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
   mac_pipe #(.WIDTH(8),  .OUT_WIDTH(16), .LATENCY(5), .SIGNED(1'b0)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
   mac_pipe #(.WIDTH(16), .OUT_WIDTH(16), .LATENCY(2), .SIGNED(1'b1)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

   function automatic int dw(input int d);
      case (d) 0: return 32; 1: return 8; default: return 16; endcase
   endfunction
   function automatic int dow(input int d);
      case (d) 0: return 64; 1: return 16; default: return 16; endcase
   endfunction
   function automatic int dlat(input int d);
      case (d) 0: return 3; 1: return 5; default: return 2; endcase
   endfunction
   function automatic bit dsg(input int d);
      return d != 1;
   endfunction

   function automatic logic [63:0] get_out(input int d);
      case (d) 0: return if0.out; 1: return 64'(if1.out); default: return 64'(if2.out); endcase
   endfunction
   function automatic logic get_vld(input int d);
      case (d) 0: return if0.out_valid; 1: return if1.out_valid; default: return if2.out_valid; endcase
   endfunction
   function automatic logic get_ovf(input int d);
      case (d) 0: return if0.ovf; 1: return if1.ovf; default: return if2.ovf; endcase
   endfunction

   task automatic drive(input int d, input bit t, input logic [31:0] a, input logic [31:0] b,
                        input bit en, input bit clr);
      case (d)
         0: begin if0.t = t; if0.a = a; if0.b = b; if0.acc_en = en; if0.acc_clr = clr; end
         1: begin if1.t = t; if1.a = a[7:0]; if1.b = b[7:0]; if1.acc_en = en; if1.acc_clr = clr; end
         default: begin if2.t = t; if2.a = a[15:0]; if2.b = b[15:0]; if2.acc_en = en; if2.acc_clr = clr; end
      endcase
   endtask

   task automatic drive_idle();
      for (int d = 0; d < 3; d++) drive(d, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
   endtask

   // ---------------- reference model: exact integers, then wrapped to the result width
   big_t m_acc [3];
   bit   m_ovf [3];

   function automatic big_t wrap(input big_t x, input int w, input bit s);
      big_t m, r;
      m = big_t'(1) << w;
      r = x & (m - 1);
      if (s && r >= m / 2) r = r - m;
      return r;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 3; d++) begin m_acc[d] = 0; m_ovf[d] = 1'b0; end
   endtask

   task automatic model_item(input int d, input logic [31:0] a, input logic [31:0] b,
                             input bit en, input bit clr, output logic [63:0] res, output bit ovf);
      int   w, ow;
      bit   s;
      big_t p, ex, lo, hi;
      w  = dw(d);
      ow = dow(d);
      s  = dsg(d);
      p  = wrap(wrap(big_t'(a), w, s) * wrap(big_t'(b), w, s), ow, s);
      if (!en) begin
         ex = p;
      end else if (clr) begin
         m_acc[d] = p;
         m_ovf[d] = 1'b0;
         ex = p;
      end else begin
         ex = m_acc[d] + p;
         lo = s ? -(big_t'(1) << (ow - 1)) : big_t'(0);
         hi = s ? (big_t'(1) << (ow - 1)) - 1 : (big_t'(1) << ow) - 1;
         if (ex < lo || ex > hi) m_ovf[d] = 1'b1;
         m_acc[d] = wrap(ex, ow, s);
         ex = m_acc[d];
      end
      res = 64'(ex & ((big_t'(1) << ow) - 1));
      ovf = m_ovf[d];
   endtask

   // ---------------- schedule and cycle-accurate runner
   bit          s_t [64], s_en [64], s_clr [64], s_rst [64];
   logic [31:0] s_a [64], s_b [64];

   task automatic clear_sched();
      for (int i = 0; i < 64; i++) begin
         s_t[i] = 0; s_en[i] = 0; s_clr[i] = 0; s_rst[i] = 0; s_a[i] = 0; s_b[i] = 0;
      end
   endtask

   task automatic set_item(input int c, input logic [31:0] a, input logic [31:0] b,
                           input bit en, input bit clr);
      s_t[c] = 1'b1; s_a[c] = a; s_b[c] = b; s_en[c] = en; s_clr[c] = clr;
   endtask

   task automatic apply_reset();
      drive_idle();
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
   endtask

   task automatic run_sched(input int d, input int n, input string name);
      bit          ev [128];
      logic [63:0] eo [128];
      bit          ef [128];
      logic [63:0] hold_o, r;
      bit          hold_f, f;
      int          lat, rst_at;
      lat = dlat(d);
      rst_at = -1;
      hold_o = 64'h0;
      hold_f = 1'b0;
      for (int k = 0; k < 128; k++) begin ev[k] = 0; eo[k] = 0; ef[k] = 0; end
      for (int c = 0; c < n + lat + 2; c++) begin
         @(posedge clk); #1;
         rst = (c < n) && s_rst[c];
         if (c < n) drive(d, s_t[c], s_a[c], s_b[c], s_en[c], s_clr[c]);
         else       drive(d, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
         if (c < n && s_t[c] && !s_rst[c]) begin
            model_item(d, s_a[c], s_b[c], s_en[c], s_clr[c], r, f);
            ev[c+lat] = 1'b1; eo[c+lat] = r; ef[c+lat] = f;
         end
         if (c < n && s_rst[c]) begin
            for (int k = c + 1; k < 128; k++) ev[k] = 1'b0;
            model_reset();
            rst_at = c + 1;
         end
         @(negedge clk);
         if (c == rst_at) begin hold_o = 64'h0; hold_f = 1'b0; end
         if (ev[c]) begin hold_o = eo[c]; hold_f = ef[c]; end
         n_checks++;
         if (get_vld(d) !== ev[c]) $display("FAIL %s out_valid cyc %0d: got %b want %b", name, c, get_vld(d), ev[c]);
         else n_pass++;
         n_checks++;
         if (get_out(d) !== hold_o) $display("FAIL %s out cyc %0d: got %h want %h", name, c, get_out(d), hold_o);
         else n_pass++;
         n_checks++;
         if (get_ovf(d) !== hold_f) $display("FAIL %s ovf cyc %0d: got %b want %b", name, c, get_ovf(d), hold_f);
         else n_pass++;
      end
      rst = 1'b0;
   endtask

   // ---------------- scenarios
   task automatic test_reset();
      drive_idle();
      drive(0, 1'b1, 32'd5, 32'd5, 1'b1, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      drive_idle();
      model_reset();
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         for (int d = 0; d < 3; d++) begin
            n_checks++;
            if (get_vld(d) !== 1'b0 || get_out(d) !== 64'h0 || get_ovf(d) !== 1'b0)
               $display("FAIL reset dut%0d cyc %0d: got v=%b o=%h f=%b want 0/0/0",
                        d, c, get_vld(d), get_out(d), get_ovf(d));
            else n_pass++;
         end
      end
   endtask

   task automatic test_signed_mul();
      apply_reset();
      clear_sched();
      set_item(0, -32'sd3, 32'd5, 1'b0, 1'b0);
      run_sched(0, 1, "signed_mul");
      n_checks++;
      if (get_out(0) !== 64'hFFFF_FFFF_FFFF_FFF1) $display("FAIL signed_mul value: got %h want %h", get_out(0), 64'hFFFF_FFFF_FFFF_FFF1);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      apply_reset();
      clear_sched();
      set_item(0, 32'd2, 32'd3, 1'b1, 1'b1);
      set_item(1, 32'd4, 32'd5, 1'b1, 1'b0);
      set_item(2, 32'd6, 32'd7, 1'b1, 1'b0);
      run_sched(0, 3, "back_to_back");
      n_checks++;
      if (get_out(0) !== 64'd68 || get_ovf(0) !== 1'b0) $display("FAIL back_to_back sum: got %0d/%b want 68/0", get_out(0), get_ovf(0));
      else n_pass++;
   endtask

   task automatic test_unsigned_ovf();
      apply_reset();
      clear_sched();
      set_item(0, 32'd255, 32'd255, 1'b1, 1'b1);
      set_item(1, 32'd255, 32'd255, 1'b1, 1'b0);
      set_item(2, 32'd1,   32'd1,   1'b1, 1'b1);
      run_sched(1, 3, "unsigned_ovf");
      n_checks++;
      if (get_out(1) !== 64'd1 || get_ovf(1) !== 1'b0) $display("FAIL unsigned_ovf clear: got %0d/%b want 1/0", get_out(1), get_ovf(1));
      else n_pass++;
   endtask

   task automatic test_gapped();
      apply_reset();
      clear_sched();
      set_item(0, 32'd3,   32'd4,   1'b0, 1'b0);
      set_item(2, 32'd200, 32'd100, 1'b0, 1'b0);
      set_item(3, 32'd17,  32'd15,  1'b0, 1'b1);
      s_en[1] = 1'b1; s_clr[1] = 1'b1;
      run_sched(1, 4, "gapped");
   endtask

   task automatic test_reset_midflight();
      apply_reset();
      clear_sched();
      set_item(0, 32'd100, 32'd100, 1'b1, 1'b1);
      set_item(1, 32'd50,  32'd50,  1'b1, 1'b0);
      s_rst[2] = 1'b1;
      set_item(3, 32'd7,   32'd6,   1'b1, 1'b0);
      run_sched(0, 4, "reset_midflight");
      n_checks++;
      if (get_out(0) !== 64'd42) $display("FAIL reset_midflight acc: got %0d want 42", get_out(0));
      else n_pass++;
   endtask

   task automatic test_lat2_trunc();
      apply_reset();
      clear_sched();
      set_item(0, 32'h7FFF, 32'd1, 1'b1, 1'b1);
      set_item(1, 32'h7FFF, 32'd1, 1'b1, 1'b0);
      set_item(2, 32'h8000, 32'd2, 1'b0, 1'b0);
      set_item(3, 32'd1,    32'd1, 1'b0, 1'b1);
      run_sched(2, 4, "lat2_trunc");
      n_checks++;
      if (get_out(2) !== 64'd1 || get_ovf(2) !== 1'b1) $display("FAIL lat2_trunc final: got %0d/%b want 1/1", get_out(2), get_ovf(2));
      else n_pass++;
   endtask

   task automatic test_random();
      for (int d = 0; d < 3; d++) begin
         apply_reset();
         clear_sched();
         for (int c = 0; c < 40; c++) begin
            s_t[c]   = ($urandom % 4) != 0;
            s_a[c]   = $urandom;
            s_b[c]   = $urandom;
            s_en[c]  = ($urandom % 4) != 0;
            s_clr[c] = ($urandom % 6) == 0;
            s_rst[c] = (c > 5) && (($urandom % 30) == 0);
         end
         run_sched(d, 40, $sformatf("random_dut%0d", d));
      end
   endtask

   initial begin
      drive_idle();
      test_reset();
      test_signed_mul();
      test_back_to_back();
      test_unsigned_ovf();
      test_gapped();
      test_reset_midflight();
      test_lat2_trunc();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mac_pipe.md
Name: mac_pipe

Overview:
- Parametrised, fully pipelined integer multiply / multiply-accumulate unit, initiation interval 1.
- Supersedes the fixed 32-bit multiplier helpers with configurable width, latency, signedness and an accumulate mode.
- Driven by HIR-generated schedules: operands are valid in the cycle `t` is high, and the result appears exactly LATENCY cycles later.
- Sits beside the other arithmetic helpers; datapaths instantiate it directly.

Parameters:
- WIDTH, 32: operand width in bits (>=2).
- OUT_WIDTH, 64: result/accumulator width (>= WIDTH, <= 2*WIDTH+16).
- LATENCY, 3: cycles from `t` to `out_valid` (>=2).
- SIGNED, 1: 1 = two's-complement operands, 0 = unsigned.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- t  input  1  item valid; a, b, acc_en, acc_clr are sampled only when t=1
- a  input  WIDTH  multiplicand
- b  input  WIDTH  multiplier
- acc_en  input  1  1 = add product into accumulator; 0 = plain multiply
- acc_clr  input  1  with acc_en: start a new sum (acc = product)
- out  output  OUT_WIDTH  result / running sum
- out_valid  output  1  out is new this cycle
- ovf  output  1  sticky accumulation overflow flag

Behaviour:
- Reset values: out=0, out_valid=0, ovf=0, accumulator=0. All in-flight valid bits are cleared.
- Reset mid-operation: items in flight are discarded and no out_valid is produced for them. The first `t` on or after the cycle rst deasserts is processed normally.
- Pipeline stages:
  - Stage 1: register a, b, t, acc_en, acc_clr.
  - Stage 2: full 2*WIDTH product, sign- or zero-extended per SIGNED.
  - Stages 3..LATENCY-1: pure delay registers on product and control, to allow DSP retiming.
  - Stage LATENCY: output/accumulate register.
- LATENCY=2 merges the product into stage 2, which is also the output stage. Timing is unchanged.
- Product width rule: the product is resized to OUT_WIDTH. Truncate the MSBs if narrower; sign-extend (SIGNED=1) or zero-extend if wider.
- Output stage, when the control valid bit is set:
  - acc_en=0: out <= product; accumulator unchanged; ovf unchanged.
  - acc_en=1, acc_clr=1: accumulator <= product; out <= product; ovf <= 0.
  - acc_en=1, acc_clr=0: accumulator <= accumulator + product, wrapping modulo 2^OUT_WIDTH; out <= new value.
  - ovf is set if the addition overflows: signed overflow for SIGNED=1, carry-out for SIGNED=0. Once set, ovf stays 1 until a clearing item or rst.
  - out_valid = 1 for exactly that cycle.
- Output stage, when the control valid bit is clear: out and accumulator hold their values; out_valid=0.
- acc_clr with acc_en=0 is ignored.
- acc_en / acc_clr with t=0 are ignored.
- Back-to-back items (t high every cycle) are fully supported. Accumulation forwards correctly because the accumulator is updated in a single stage: item n+1 sees the sum that includes item n.
- Gaps in t produce matching gaps in out_valid. Relative timing is preserved exactly.
- Truncation in the product resize is silent; ovf reflects the accumulate addition only.
- No back-pressure: the consumer must accept the result in the out_valid cycle.

Decomposition:
- Package hir_arith_pkg holds:
  - MAC_MIN_LATENCY = 2.
  - Function resize_ext(value, signed) for the width rule.
  - Elaboration-time parameter check (assertion) for the legal ranges above.
- One sub-module, delay_line: parametrised WIDTH x DEPTH shift register with synchronous reset, supporting DEPTH=0 pass-through. It is used for the product and control delay stages.

Test Plan:
- Signed multiply, defaults: t=1, a=-3, b=5, acc_en=0 at cycle 0 -> out=-15 (0xFFFF_FFFF_FFFF_FFF1), out_valid=1 at cycle 3 only.
- Back-to-back accumulate: (2,3,clr), (4,5), (6,7) in cycles 0-2 -> out = 6, 26, 68 at cycles 3-5; ovf=0.
- Unsigned overflow, WIDTH=8, OUT_WIDTH=16, SIGNED=0: (255,255,clr), then (255,255) -> 65025, then 64514 with ovf=1. A following clearing item (1,1,clr) -> out=1, ovf=0.
- Gapped issue, LATENCY=5: t at cycles 0, 2, 3 with plain multiplies -> out_valid at cycles 5, 7, 8 with the correct products. out holds its value at cycle 6.
- Reset mid-flight: issue items at cycles 0-1, rst=1 at cycle 2 -> no out_valid for those items; out=0, ovf=0. A new item at cycle 3 -> valid at cycle 6.
- LATENCY=2, WIDTH=16, OUT_WIDTH=16, signed: a=-32768, b=2 -> product truncated to 0, out_valid at cycle 2, ovf unchanged.
